vram_arbiter: RTL and testbench

- Sits directly upstream of the video controller. Serves its toggle-handshake VRAM fetches (vram_rd, vram_addr1/2 in; vram_dout1/2 out) and CPU byte accesses against one pipelined, fixed-latency 16-bit memory port.
- Video fetches always win arbitration. The CPU is served in the remaining cycles.
- Each video fetch is returned as an atomic pair of 16-bit words, before the next 8-pixel fetch boundary.

---
 rtl/vram_arb_pkg.sv | 33 +++
 rtl/vram_tag_pipe.sv | 33 +++
 rtl/vram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: FSM states, return tags,
// and the legal range of memory read latency.
package vram_arb_pkg;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 6;

    typedef enum logic [1:0] {
        IDLE,
        V1,
        V2,
        CPU
    } state_t;

    typedef enum logic [1:0] {
        VA,
        VB,
        CR
    } tag_t;

    // One slot of the return-tag delay line; lane travels with CPU reads so
    // the byte select cannot be disturbed by a later request.
    typedef struct packed {
        logic valid;
        tag_t tag;
        logic lane;
    } tag_entry_t;

    function automatic logic [1:0] lane_be(input logic lane);
        return {lane, ~lane};
    endfunction

endpackage

// File: rtl/vram_tag_pipe.sv
// Fixed-depth delay line for {valid, tag, lane}; the output slot lines up
// with the cycle in which the memory presents the matching read data.
module vram_tag_pipe
    import vram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_sys,
    input  logic       clear,
    input  tag_entry_t din,
    output tag_entry_t dout
);

    tag_entry_t stage [DEPTH];

    // NOTE: the delay line is cleared on reset because stale valid bits would
    // deliver phantom returns; plain data registers elsewhere need no reset.
    always_ff @(posedge clk_sys) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates video pair fetches (always first) and CPU byte accesses onto a
// single pipelined, fixed-latency 16-bit memory port.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int AW      = 19
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vram_rd,
    input  logic [AW-1:0] vram_addr1,
    input  logic [AW-1:0] vram_addr2,
    output logic [15:0]   vram_dout1,
    output logic [15:0]   vram_dout2,
    output logic          vid_overrun,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW:0]   cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [15:0]   mem_din,
    input  logic [15:0]   mem_dout
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("vram_arbiter: MEM_LAT outside supported range");
    end

    state_t        state;
    logic          vrd_seen;
    logic          vid_pend;
    logic          cpu_pend;
    logic [AW-1:0] addr1_q;
    logic [AW-1:0] addr2_q;
    logic [AW-1:0] cpu_word_q;
    logic          cpu_lane_q;
    logic          cpu_wr_q;
    logic [7:0]    cpu_din_q;
    logic [15:0]   hold;
    tag_entry_t    issue;
    tag_entry_t    ret;
    logic          toggle;
    logic          cpu_take;

    assign toggle   = (vram_rd != vrd_seen);
    assign cpu_take = cpu_req && !cpu_pend;

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch below reads the pre-edge values of its neighbours.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            vrd_seen    <= vram_rd;
            vid_pend    <= 1'b0;
            cpu_pend    <= 1'b0;
            vid_overrun <= 1'b0;
            mem_rd      <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 2'b00;
            mem_addr    <= '0;
            mem_din     <= '0;
            issue       <= '0;
        end else begin
            mem_rd <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 2'b00;
            issue  <= '0;

            if (toggle) begin
                vrd_seen <= vram_rd;
                addr1_q  <= vram_addr1;
                addr2_q  <= vram_addr2;
                vid_pend <= 1'b1;
                if (vid_pend || state == V1 || state == V2) begin
                    vid_overrun <= 1'b1;
                end
            end

            if (cpu_take) begin
                cpu_pend   <= 1'b1;
                cpu_wr_q   <= cpu_wr;
                cpu_word_q <= cpu_addr[AW:1];
                cpu_lane_q <= cpu_addr[0];
                cpu_din_q  <= cpu_din;
            end

            // Each branch sets up the port for the cycle spent in the next state.
            case (state)
                IDLE: begin
                    if (vid_pend || toggle) begin
                        state    <= V1;
                        mem_rd   <= 1'b1;
                        mem_addr <= toggle ? vram_addr1 : addr1_q;
                        issue    <= '{valid: 1'b1, tag: VA, lane: 1'b0};
                    end else if (cpu_pend) begin
                        state    <= CPU;
                        mem_addr <= cpu_word_q;
                        if (cpu_wr_q) begin
                            mem_we  <= 1'b1;
                            mem_be  <= lane_be(cpu_lane_q);
                            mem_din <= {2{cpu_din_q}};
                        end else begin
                            mem_rd <= 1'b1;
                            issue  <= '{valid: 1'b1, tag: CR, lane: cpu_lane_q};
                        end
                    end
                end
                V1: begin
                    state    <= V2;
                    mem_rd   <= 1'b1;
                    mem_addr <= addr2_q;
                    issue    <= '{valid: 1'b1, tag: VB, lane: 1'b0};
                end
                V2: begin
                    state <= IDLE;
                    // A toggle landing now is a fresh fetch and must survive.
                    if (!toggle) begin
                        vid_pend <= 1'b0;
                    end
                end
                CPU: begin
                    state    <= IDLE;
                    cpu_pend <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    vram_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk_sys (clk_sys),
        .clear   (reset),
        .din     (issue),
        .dout    (ret)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vram_dout1 <= '0;
            vram_dout2 <= '0;
            cpu_dout   <= '0;
            cpu_ack    <= 1'b0;
            hold       <= '0;
        end else begin
            cpu_ack <= (state == CPU && cpu_wr_q) || (ret.valid && ret.tag == CR);
            if (ret.valid) begin
                case (ret.tag)
                    VA: hold <= mem_dout;
                    VB: begin
                        vram_dout1 <= hold;
                        vram_dout2 <= mem_dout;
                    end
                    CR: cpu_dout <= ret.lane ? mem_dout[15:8] : mem_dout[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: three instances (MEM_LAT 2, 1, 6) share stimulus,
// each with its own pipelined memory model; instance 0 is fully scoreboarded.
module tb_vram_arbiter;

    localparam int AW = 19;
    localparam int N  = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 6;
    endfunction

    function automatic logic [15:0] dflt(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          vram_rd;
    logic [AW-1:0] vram_addr1;
    logic [AW-1:0] vram_addr2;
    logic          cpu_req;
    logic          cpu_wr;
    logic [AW:0]   cpu_addr;
    logic [7:0]    cpu_din;

    wire [15:0]   vd1   [N];
    wire [15:0]   vd2   [N];
    wire          ovr   [N];
    wire [7:0]    cdout [N];
    wire          cack  [N];
    wire [AW-1:0] maddr [N];
    wire          mrd   [N];
    wire          mwe   [N];
    wire [1:0]    mbe   [N];
    wire [15:0]   mdin  [N];
    wire [15:0]   mdout [N];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_lat
        localparam int L = lat_of(g);
        logic [15:0] mem [int];
        logic [15:0] rpipe [L];
        logic [15:0] wtmp;
        int          wa;

        vram_arbiter #(.MEM_LAT(L), .AW(AW)) u_dut (
            .clk_sys     (clk_sys),
            .reset       (reset),
            .vram_rd     (vram_rd),
            .vram_addr1  (vram_addr1),
            .vram_addr2  (vram_addr2),
            .vram_dout1  (vd1[g]),
            .vram_dout2  (vd2[g]),
            .vid_overrun (ovr[g]),
            .cpu_req     (cpu_req),
            .cpu_wr      (cpu_wr),
            .cpu_addr    (cpu_addr),
            .cpu_din     (cpu_din),
            .cpu_dout    (cdout[g]),
            .cpu_ack     (cack[g]),
            .mem_addr    (maddr[g]),
            .mem_rd      (mrd[g]),
            .mem_we      (mwe[g]),
            .mem_be      (mbe[g]),
            .mem_din     (mdin[g]),
            .mem_dout    (mdout[g])
        );

        initial begin
            mem[32'h100] = 16'hA55A;
            mem[32'h102] = 16'h1234;
            for (int i = 0; i < L; i++) rpipe[i] = 16'hDEAD;
        end

        always @(posedge clk_sys) begin
            wa = int'(maddr[g]);
            if (mwe[g]) begin
                wtmp = mem.exists(wa) ? mem[wa] : dflt(maddr[g]);
                if (mbe[g][0]) wtmp[7:0]  = mdin[g][7:0];
                if (mbe[g][1]) wtmp[15:8] = mdin[g][15:8];
                mem[wa] = wtmp;
            end
            rpipe[0] <= mrd[g] ? (mem.exists(wa) ? mem[wa] : dflt(maddr[g])) : 16'hDEAD;
            for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
        end

        assign mdout[g] = rpipe[L-1];
    end

    typedef struct { int cyc; bit rd; bit we; logic [AW-1:0] addr; logic [1:0] be; logic [15:0] din; } iss_t;
    typedef struct { int cyc; logic [15:0] d1; logic [15:0] d2; } vid_t;
    typedef struct { int cyc; logic [7:0] d; } ack_t;
    typedef struct { logic [15:0] d1; logic [15:0] d2; } pair_t;

    iss_t        iss_q[$];
    vid_t        vid_q[$];
    ack_t        ack_q[$];
    pair_t       exp_vid_q[$];
    logic [7:0]  exp_cpu_q[$];
    logic [15:0] last_d1 = '0;
    logic [15:0] last_d2 = '0;
    bit          both_hi = 1'b0;

    // Event log of instance 0, sampled mid-cycle.
    always @(negedge clk_sys) begin
        if (mrd[0] || mwe[0]) iss_q.push_back('{cyc, mrd[0], mwe[0], maddr[0], mbe[0], mdin[0]});
        if (mrd[0] && mwe[0]) both_hi = 1'b1;
        if (vd1[0] !== last_d1 || vd2[0] !== last_d2) begin
            vid_q.push_back('{cyc, vd1[0], vd2[0]});
            last_d1 = vd1[0];
            last_d2 = vd2[0];
        end
        if (cack[0]) ack_q.push_back('{cyc, cdout[0]});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic clear_logs();
        iss_q.delete();
        vid_q.delete();
        ack_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; vram_rd = 1'b1; vram_addr1 = '0; vram_addr2 = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
        tick(3);
        reset = 1'b0;
        clear_logs();
        tick(5);
        checks++;
        if (iss_q.size() != 0) begin
            failures++;
            $display("FAIL reset_idle_issues: got %0d issues, expected 0", iss_q.size());
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (vd1[i] !== 16'h0 || vd2[i] !== 16'h0 || cdout[i] !== 8'h0 || cack[i] !== 1'b0 ||
                ovr[i] !== 1'b0 || mrd[i] !== 1'b0 || mwe[i] !== 1'b0 || mbe[i] !== 2'b00 || maddr[i] !== '0) begin
                failures++;
                $display("FAIL reset_values[%0d]: got d1=%h d2=%h cd=%h ack=%b ovr=%b rd=%b we=%b be=%b addr=%h, expected all 0",
                         i, vd1[i], vd2[i], cdout[i], cack[i], ovr[i], mrd[i], mwe[i], mbe[i], maddr[i]);
            end
        end
    endtask

    task automatic test_latency();
        int c0;
        logic [AW-1:0] ea [2];
        pair_t p;
        ea[0] = 19'h100; ea[1] = 19'h102;
        clear_logs();
        vram_addr1 = 19'h100; vram_addr2 = 19'h102;
        exp_vid_q.push_back('{16'hA55A, 16'h1234});
        vram_rd = ~vram_rd;
        c0 = cyc + 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (cyc == c0 + lat_of(i) + 1) begin
                    checks++;
                    if (vd1[i] !== 16'h0 || vd2[i] !== 16'h0) begin
                        failures++;
                        $display("FAIL lat_early[%0d]: got %h/%h, expected 0000/0000", i, vd1[i], vd2[i]);
                    end
                end
                if (cyc == c0 + lat_of(i) + 2) begin
                    checks++;
                    if (vd1[i] !== 16'hA55A || vd2[i] !== 16'h1234) begin
                        failures++;
                        $display("FAIL lat_pair[%0d] (MEM_LAT=%0d): got %h/%h, expected a55a/1234",
                                 i, lat_of(i), vd1[i], vd2[i]);
                    end
                end
            end
        end
        checks++;
        if (iss_q.size() != 2) begin
            failures++;
            $display("FAIL lat_issue_count: got %0d, expected 2", iss_q.size());
        end else begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (!iss_q[j].rd || iss_q[j].addr !== ea[j] || iss_q[j].cyc != c0 + j) begin
                    failures++;
                    $display("FAIL lat_issue%0d: got rd=%b addr=%h cyc=%0d, expected rd=1 addr=%h cyc=%0d",
                             j, iss_q[j].rd, iss_q[j].addr, iss_q[j].cyc, ea[j], c0 + j);
                end
            end
        end
        p = exp_vid_q.pop_front();
        checks++;
        if (vid_q.size() != 1 || vid_q[0].d1 !== p.d1 || vid_q[0].d2 !== p.d2 || vid_q[0].cyc != c0 + 4) begin
            failures++;
            $display("FAIL lat_scoreboard: got %0d updates first=%h/%h@%0d, expected 1 update %h/%h@%0d",
                     vid_q.size(), last_d1, last_d2, (vid_q.size() > 0) ? vid_q[0].cyc : -1, p.d1, p.d2, c0 + 4);
        end
    endtask

    task automatic do_cpu(input bit wr, input logic [AW:0] addr, input logic [7:0] din,
                          input logic [7:0] exp, input string name);
        int ic;
        logic [7:0] e;
        clear_logs();
        if (!wr) exp_cpu_q.push_back(exp);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_din = din;
        tick();
        cpu_req = 1'b0;
        tick(16);
        checks++;
        if (iss_q.size() != 1) begin
            failures++;
            $display("FAIL %s_issue_count: got %0d, expected 1", name, iss_q.size());
            ic = 0;
        end else begin
            ic = iss_q[0].cyc;
            checks++;
            if (iss_q[0].we !== wr || iss_q[0].rd !== !wr || iss_q[0].addr !== addr[AW:1]) begin
                failures++;
                $display("FAIL %s_issue: got rd=%b we=%b addr=%h, expected rd=%b we=%b addr=%h",
                         name, iss_q[0].rd, iss_q[0].we, iss_q[0].addr, !wr, wr, addr[AW:1]);
            end
            if (wr) begin
                checks++;
                if (iss_q[0].be !== {addr[0], ~addr[0]} || iss_q[0].din !== {din, din}) begin
                    failures++;
                    $display("FAIL %s_wdata: got be=%b din=%h, expected be=%b din=%h",
                             name, iss_q[0].be, iss_q[0].din, {addr[0], ~addr[0]}, {din, din});
                end
            end
        end
        checks++;
        if (ack_q.size() != 1 || ack_q[0].cyc != ic + (wr ? 1 : lat_of(0) + 1)) begin
            failures++;
            $display("FAIL %s_ack: got %0d acks first@%0d, expected 1 ack @%0d", name, ack_q.size(),
                     (ack_q.size() > 0) ? ack_q[0].cyc : -1, ic + (wr ? 1 : lat_of(0) + 1));
        end
        if (!wr) begin
            e = exp_cpu_q.pop_front();
            checks++;
            if (ack_q.size() < 1 || ack_q[0].d !== e) begin
                failures++;
                $display("FAIL %s_rdata: got %h, expected %h", name, (ack_q.size() > 0) ? ack_q[0].d : 8'hxx, e);
            end
        end
    endtask

    task automatic test_cpu();
        do_cpu(1'b1, 20'h00201, 8'h7E, 8'h00, "cpu_wr");
        do_cpu(1'b0, 20'h00201, 8'h00, 8'h7E, "cpu_rd");
    endtask

    task automatic test_simultaneous();
        pair_t p;
        logic [7:0] e;
        clear_logs();
        vram_addr1 = 19'h300; vram_addr2 = 19'h302;
        exp_vid_q.push_back('{dflt(19'h300), dflt(19'h302)});
        exp_cpu_q.push_back(8'h12);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 20'h00205;
        vram_rd = ~vram_rd;
        tick();
        cpu_req = 1'b0;
        tick(20);
        checks++;
        if (iss_q.size() != 3) begin
            failures++;
            $display("FAIL sim_issue_count: got %0d, expected 3", iss_q.size());
        end else begin
            checks++;
            if (iss_q[0].addr !== 19'h300 || iss_q[1].addr !== 19'h302 || iss_q[2].addr !== 19'h102 ||
                !iss_q[2].rd || iss_q[1].cyc != iss_q[0].cyc + 1) begin
                failures++;
                $display("FAIL sim_issue_order: got %h,%h,%h, expected 00300,00302,00102",
                         iss_q[0].addr, iss_q[1].addr, iss_q[2].addr);
            end
        end
        p = exp_vid_q.pop_front();
        checks++;
        if (vid_q.size() != 1 || last_d1 !== p.d1 || last_d2 !== p.d2) begin
            failures++;
            $display("FAIL sim_vid: got %0d updates final=%h/%h, expected 1 update %h/%h",
                     vid_q.size(), last_d1, last_d2, p.d1, p.d2);
        end
        e = exp_cpu_q.pop_front();
        checks++;
        if (ack_q.size() != 1 || ack_q[0].d !== e) begin
            failures++;
            $display("FAIL sim_cpu: got %0d acks data=%h, expected 1 ack data=%h",
                     ack_q.size(), (ack_q.size() > 0) ? ack_q[0].d : 8'hxx, e);
        end
    endtask

    task automatic test_overrun();
        pair_t p;
        logic [AW-1:0] ea [4];
        ea[0] = 19'h400; ea[1] = 19'h402; ea[2] = 19'h500; ea[3] = 19'h502;
        clear_logs();
        vram_addr1 = 19'h400; vram_addr2 = 19'h402;
        exp_vid_q.push_back('{dflt(19'h400), dflt(19'h402)});
        exp_vid_q.push_back('{dflt(19'h500), dflt(19'h502)});
        vram_rd = ~vram_rd;
        tick(2);
        checks++;
        if (ovr[0] !== 1'b0) begin
            failures++;
            $display("FAIL ovr_before: got %b, expected 0", ovr[0]);
        end
        vram_addr1 = 19'h500; vram_addr2 = 19'h502;
        vram_rd = ~vram_rd;
        tick(25);
        checks++;
        if (ovr[0] !== 1'b1) begin
            failures++;
            $display("FAIL ovr_set: got %b, expected 1", ovr[0]);
        end
        checks++;
        if (iss_q.size() != 4) begin
            failures++;
            $display("FAIL ovr_issue_count: got %0d, expected 4", iss_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (!iss_q[j].rd || iss_q[j].addr !== ea[j]) begin
                    failures++;
                    $display("FAIL ovr_issue%0d: got rd=%b addr=%h, expected rd=1 addr=%h",
                             j, iss_q[j].rd, iss_q[j].addr, ea[j]);
                end
            end
        end
        checks++;
        if (vid_q.size() != 2) begin
            failures++;
            $display("FAIL ovr_vid_count: got %0d updates, expected 2", vid_q.size());
        end
        for (int j = 0; j < 2; j++) begin
            p = exp_vid_q.pop_front();
            if (vid_q.size() > j) begin
                checks++;
                if (vid_q[j].d1 !== p.d1 || vid_q[j].d2 !== p.d2) begin
                    failures++;
                    $display("FAIL ovr_pair%0d: got %h/%h, expected %h/%h", j, vid_q[j].d1, vid_q[j].d2, p.d1, p.d2);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        vram_addr1 = 19'h600; vram_addr2 = 19'h602;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 20'h00203;
        vram_rd = ~vram_rd;
        tick();
        cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(15);
        checks++;
        if (iss_q.size() != 2 || ack_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_port: got %0d issues %0d acks, expected 2 issues 0 acks", iss_q.size(), ack_q.size());
        end
        checks++;
        if (vid_q.size() != 1 || vid_q[0].d1 !== 16'h0 || vid_q[0].d2 !== 16'h0) begin
            failures++;
            $display("FAIL rstmid_vid: got %0d updates final=%h/%h, expected one clear to 0000/0000",
                     vid_q.size(), last_d1, last_d2);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (vd1[i] !== 16'h0 || vd2[i] !== 16'h0 || cack[i] !== 1'b0 || ovr[i] !== 1'b0 || mrd[i] !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_state[%0d]: got d1=%h d2=%h ack=%b ovr=%b rd=%b, expected all 0",
                         i, vd1[i], vd2[i], cack[i], ovr[i], mrd[i]);
            end
        end
        checks++;
        if (both_hi) begin
            failures++;
            $display("FAIL port_exclusive: got mem_rd and mem_we high together, expected never");
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_cpu();
        test_simultaneous();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
